// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer driven by a 1 Hz enable tick.
// Handles load, start, pause and the alarm that follows expiry.
// Control pulses act on any clock edge. Counting and alarm timing only
// advance on edges where en_1hz is high.
// Within one cycle the inputs are ranked rst > load > pause > start > en_1hz.
// An input that the current state ignores does not block the lower-ranked ones.
// Build option: define COUNTDOWN_AUTO_RELOAD_EN to enable auto-reload.
// At expiry the count then reloads and keeps running, and the alarm times
// out on its own, independent of the FSM.
//
// state | meaning
// IDLE  | stopped; waiting for load or start
// RUN   | counting down once per en_1hz tick
// PAUSE | halted mid-count; start resumes
// ALARM | count expired; alarm asserted until acknowledged or timed out
module countdown_timer #(
    parameter int unsigned ALARM_TICKS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_1hz,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       done,
    output logic       alarm
);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AUTO_RELOAD = 1'b1;
`else
    localparam bit AUTO_RELOAD = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

    state_t      state;
    logic [7:0]  rld_min;
    logic [7:0]  rld_sec;
    logic [7:0]  alarm_cnt;

    logic [7:0]  ld_min;
    logic [7:0]  ld_sec;
    logic [15:0] dec_val;
    logic        count_zero;
    logic        dec_zero;
    logic        reload_nz;
    logic        alarm_last;
    logic        alarm_ack;

    // Clamp each digit to its largest legal value so that bad BCD never reaches the counter.
    function automatic logic [7:0] clamp_digits(input logic [7:0] v, input logic [3:0] tens_max);
        logic [3:0] t;
        logic [3:0] o;
        t = (v[7:4] > tens_max) ? tens_max : v[7:4];
        o = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
        return {t, o};
    endfunction

    // Subtract one second from mm:ss, borrowing across the BCD digit boundaries.
    function automatic logic [15:0] dec_mmss(input logic [7:0] m, input logic [7:0] s);
        logic [7:0] nm;
        logic [7:0] ns;
        nm = m;
        ns = s;
        if (s[3:0] != 4'd0) begin
            ns[3:0] = s[3:0] - 4'd1;
        end else if (s[7:4] != 4'd0) begin
            ns = {s[7:4] - 4'd1, 4'd9};
        end else if (m != 8'h00) begin
            ns = 8'h59;
            if (m[3:0] != 4'd0) nm[3:0] = m[3:0] - 4'd1;
            else                nm = {m[7:4] - 4'd1, 4'd9};
        end
        return {nm, ns};
    endfunction

    // Next-value helpers shared by the FSM.
    always_comb begin
        ld_min     = clamp_digits(load_min, 4'd9);
        ld_sec     = clamp_digits(load_sec, 4'd5);
        dec_val    = dec_mmss(min_bcd, sec_bcd);
        count_zero = (min_bcd == 8'h00) && (sec_bcd == 8'h00);
        dec_zero   = (dec_val == 16'h0000);
        reload_nz  = (rld_min != 8'h00) || (rld_sec != 8'h00);
        // The alarm ends on the tick at which its counter reaches ALARM_TICKS-1.
        alarm_last = ((32'(alarm_cnt) + 32'd1) >= (ALARM_TICKS - 32'd1));
        // With auto-reload, an alarm that rings while running is only acknowledged.
        alarm_ack  = AUTO_RELOAD && alarm && (pause || start);
    end

    // Main FSM with registered count, running, done and alarm outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            min_bcd   <= 8'h00;
            sec_bcd   <= 8'h00;
            rld_min   <= 8'h00;
            rld_sec   <= 8'h00;
            running   <= 1'b0;
            done      <= 1'b0;
            alarm     <= 1'b0;
            alarm_cnt <= 8'd0;
        end else begin
            done <= 1'b0;
            if (load && state != RUN) begin
                min_bcd   <= ld_min;
                sec_bcd   <= ld_sec;
                rld_min   <= ld_min;
                rld_sec   <= ld_sec;
                state     <= IDLE;
                running   <= 1'b0;
                alarm     <= 1'b0;
                alarm_cnt <= 8'd0;
            end else begin
                case (state)
                    IDLE, PAUSE: begin
                        if (start && !count_zero) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (AUTO_RELOAD && alarm) begin
                            if (pause || start) begin
                                alarm <= 1'b0;
                            end else if (en_1hz) begin
                                if (alarm_last) alarm <= 1'b0;
                                else            alarm_cnt <= alarm_cnt + 8'd1;
                            end
                        end
                        if (pause && !alarm_ack) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else if (en_1hz) begin
                            if (dec_zero) begin
                                done      <= 1'b1;
                                alarm     <= 1'b1;
                                alarm_cnt <= 8'd0;
                                if (AUTO_RELOAD && reload_nz) begin
                                    min_bcd <= rld_min;
                                    sec_bcd <= rld_sec;
                                end else begin
                                    min_bcd <= 8'h00;
                                    sec_bcd <= 8'h00;
                                    state   <= ALARM;
                                    running <= 1'b0;
                                end
                            end else begin
                                min_bcd <= dec_val[15:8];
                                sec_bcd <= dec_val[7:0];
                            end
                        end
                    end
                    ALARM: begin
                        if (pause || start) begin
                            alarm <= 1'b0;
                            state <= IDLE;
                        end else if (en_1hz) begin
                            if (alarm_last) begin
                                alarm <= 1'b0;
                                state <= IDLE;
                            end else begin
                                alarm_cnt <= alarm_cnt + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed vector table plus
// randomized stimulus checked against a seconds-based behavioural model.
module tb_countdown_timer;

    localparam int unsigned AT = 5;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_1hz = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_min = 8'h00;
    logic [7:0] load_sec = 8'h00;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic       done;
    logic       alarm;

    countdown_timer #(.ALARM_TICKS(AT)) dut (
        .clk      (clk),
        .rst      (rst),
        .en_1hz   (en_1hz),
        .load     (load),
        .load_min (load_min),
        .load_sec (load_sec),
        .start    (start),
        .pause    (pause),
        .min_bcd  (min_bcd),
        .sec_bcd  (sec_bcd),
        .running  (running),
        .done     (done),
        .alarm    (alarm)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: the count is held as a plain number of seconds.
    int m_cnt = 0;
    int m_rld = 0;
    bit m_run = 1'b0;
    bit m_alarm = 1'b0;
    bit m_done = 1'b0;
    int m_left = 0;

    typedef struct {
        logic       r;
        logic       l;
        logic [7:0] lm;
        logic [7:0] ls;
        logic       s;
        logic       p;
        logic       t;
        logic [7:0] emin;
        logic [7:0] esec;
        logic       erun;
        logic       edone;
        logic       ealarm;
    } vec_t;

    vec_t tbl[$];

    function automatic int clamp_val(input logic [7:0] v, input int tmax);
        int t;
        int o;
        t = (int'(v[7:4]) > tmax) ? tmax : int'(v[7:4]);
        o = (int'(v[3:0]) > 9) ? 9 : int'(v[3:0]);
        return t * 10 + o;
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        return 8'(((n / 10) * 16) + (n % 10));
    endfunction

    task automatic alarm_tick_model(input logic p, input logic s, input logic t);
        if (p || s) m_alarm = 1'b0;
        else if (t) begin
            if (m_left <= 1) m_alarm = 1'b0;
            else             m_left = m_left - 1;
        end
    endtask

    task automatic model_step(input logic r, input logic l, input logic [7:0] lm, input logic [7:0] ls,
                              input logic s, input logic p, input logic t);
        bit ack;
        m_done = 1'b0;
        if (r) begin
            m_cnt = 0; m_rld = 0; m_run = 1'b0; m_alarm = 1'b0; m_left = 0;
        end else if (l && !m_run) begin
            m_cnt   = clamp_val(lm, 9) * 60 + clamp_val(ls, 5);
            m_rld   = m_cnt;
            m_alarm = 1'b0;
        end else if (m_alarm && !m_run) begin
            alarm_tick_model(p, s, t);
        end else begin
            ack = AUTO && m_alarm && (p || s);
            if (m_alarm) alarm_tick_model(p, s, t);
            if (m_run) begin
                if (p && !ack) m_run = 1'b0;
                else if (t) begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) begin
                        m_done  = 1'b1;
                        m_alarm = 1'b1;
                        m_left  = int'(AT) - 1;
                        if (AUTO && m_rld != 0) m_cnt = m_rld;
                        else                    m_run = 1'b0;
                    end
                end
            end else if (s && m_cnt != 0) begin
                m_run = 1'b1;
            end
        end
    endtask

    task automatic check_vec(input string name, input logic [7:0] emin, input logic [7:0] esec,
                             input logic erun, input logic edone, input logic ealarm);
        tests++;
        if (min_bcd !== emin || sec_bcd !== esec || running !== erun || done !== edone || alarm !== ealarm) begin
            fails++;
            $display("FAIL %s: got %h:%h run=%b done=%b alarm=%b, expected %h:%h run=%b done=%b alarm=%b",
                     name, min_bcd, sec_bcd, running, done, alarm, emin, esec, erun, edone, ealarm);
        end
    endtask

    task automatic check_model(input string name);
        check_vec(name, to_bcd(m_cnt / 60), to_bcd(m_cnt % 60), m_run, m_done, m_alarm);
    endtask

    // Apply one cycle of inputs, advance the model on the edge, settle past it.
    task automatic drive(input logic r, input logic l, input logic [7:0] lm, input logic [7:0] ls,
                         input logic s, input logic p, input logic t);
        rst = r; load = l; load_min = lm; load_sec = ls; start = s; pause = p; en_1hz = t;
        @(posedge clk);
        model_step(r, l, lm, ls, s, p, t);
        #1;
    endtask

    task automatic row(input logic r, input logic l, input logic [7:0] lm, input logic [7:0] ls,
                       input logic s, input logic p, input logic t,
                       input logic [7:0] em, input logic [7:0] es, input logic er, input logic ed, input logic ea);
        vec_t v;
        v.r = r; v.l = l; v.lm = lm; v.ls = ls; v.s = s; v.p = p; v.t = t;
        v.emin = em; v.esec = es; v.erun = er; v.edone = ed; v.ealarm = ea;
        tbl.push_back(v);
    endtask

    initial begin
        logic       r_r, r_l, r_s, r_p, r_t;
        logic [7:0] r_lm, r_ls;

        // Columns: rst load lmin lsec start pause tick | min sec run done alarm
`ifndef COUNTDOWN_AUTO_RELOAD_EN
        row(1,0,8'h00,8'h00,0,0,0, 8'h00,8'h00,0,0,0);
        row(1,0,8'h00,8'h00,0,0,1, 8'h00,8'h00,0,0,0);
        row(0,0,8'h00,8'h00,1,0,0, 8'h00,8'h00,0,0,0);
        row(0,1,8'h00,8'h03,0,0,0, 8'h00,8'h03,0,0,0);
        row(0,0,8'h00,8'h00,1,0,0, 8'h00,8'h03,1,0,0);
        row(0,0,8'h00,8'h00,0,0,1, 8'h00,8'h02,1,0,0);
        row(0,0,8'h00,8'h00,0,0,1, 8'h00,8'h01,1,0,0);
        row(0,0,8'h00,8'h00,0,0,1, 8'h00,8'h00,0,1,1);
        row(0,0,8'h00,8'h00,0,0,0, 8'h00,8'h00,0,0,1);
        row(0,0,8'h00,8'h00,0,0,1, 8'h00,8'h00,0,0,1);
        row(0,0,8'h00,8'h00,0,0,1, 8'h00,8'h00,0,0,1);
        row(0,0,8'h00,8'h00,0,0,1, 8'h00,8'h00,0,0,1);
        row(0,0,8'h00,8'h00,0,0,1, 8'h00,8'h00,0,0,0);
        row(0,0,8'h00,8'h00,1,0,0, 8'h00,8'h00,0,0,0);
        row(0,1,8'h01,8'h00,0,0,0, 8'h01,8'h00,0,0,0);
        row(0,0,8'h00,8'h00,1,0,0, 8'h01,8'h00,1,0,0);
        row(0,0,8'h00,8'h00,0,0,1, 8'h00,8'h59,1,0,0);
        row(0,0,8'h00,8'h00,0,1,0, 8'h00,8'h59,0,0,0);
        row(0,1,8'h10,8'h00,0,0,0, 8'h10,8'h00,0,0,0);
        row(0,0,8'h00,8'h00,1,0,1, 8'h10,8'h00,1,0,0);
        row(0,0,8'h00,8'h00,0,0,1, 8'h09,8'h59,1,0,0);
        row(0,0,8'h00,8'h00,0,1,1, 8'h09,8'h59,0,0,0);
        row(0,1,8'h7C,8'hAF,0,0,0, 8'h79,8'h59,0,0,0);
        row(0,1,8'hA0,8'h6A,0,0,0, 8'h90,8'h59,0,0,0);
        row(0,1,8'h00,8'h10,0,0,0, 8'h00,8'h10,0,0,0);
        row(0,0,8'h00,8'h00,1,0,0, 8'h00,8'h10,1,0,0);
        row(0,0,8'h00,8'h00,0,1,1, 8'h00,8'h10,0,0,0);
        for (int i = 0; i < 5; i++) row(0,0,8'h00,8'h00,0,0,1, 8'h00,8'h10,0,0,0);
        row(0,0,8'h00,8'h00,1,0,0, 8'h00,8'h10,1,0,0);
        row(0,0,8'h00,8'h00,0,0,1, 8'h00,8'h09,1,0,0);
        row(0,1,8'h05,8'h00,0,0,0, 8'h00,8'h09,1,0,0);
        row(1,0,8'h00,8'h00,0,0,1, 8'h00,8'h00,0,0,0);
        row(0,1,8'h00,8'h01,0,0,0, 8'h00,8'h01,0,0,0);
        row(0,0,8'h00,8'h00,1,0,0, 8'h00,8'h01,1,0,0);
        row(0,0,8'h00,8'h00,0,0,1, 8'h00,8'h00,0,1,1);
        row(0,0,8'h00,8'h00,0,1,0, 8'h00,8'h00,0,0,0);
        row(0,1,8'h00,8'h01,0,0,0, 8'h00,8'h01,0,0,0);
        row(0,0,8'h00,8'h00,1,0,0, 8'h00,8'h01,1,0,0);
        row(0,0,8'h00,8'h00,0,0,1, 8'h00,8'h00,0,1,1);
        row(0,1,8'h00,8'h02,0,0,0, 8'h00,8'h02,0,0,0);
        row(0,0,8'h00,8'h00,1,0,0, 8'h00,8'h02,1,0,0);
        row(0,0,8'h00,8'h00,0,0,1, 8'h00,8'h01,1,0,0);
        row(0,0,8'h00,8'h00,0,0,1, 8'h00,8'h00,0,1,1);
        row(1,0,8'h00,8'h00,0,0,0, 8'h00,8'h00,0,0,0);
`else
        row(1,0,8'h00,8'h00,0,0,0, 8'h00,8'h00,0,0,0);
        row(0,1,8'h00,8'h02,0,0,0, 8'h00,8'h02,0,0,0);
        row(0,0,8'h00,8'h00,1,0,0, 8'h00,8'h02,1,0,0);
        row(0,0,8'h00,8'h00,0,0,1, 8'h00,8'h01,1,0,0);
        row(0,0,8'h00,8'h00,0,0,1, 8'h00,8'h02,1,1,1);
        row(0,0,8'h00,8'h00,0,1,0, 8'h00,8'h02,1,0,0);
        row(0,0,8'h00,8'h00,0,0,1, 8'h00,8'h01,1,0,0);
`endif

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].l, tbl[i].lm, tbl[i].ls, tbl[i].s, tbl[i].p, tbl[i].t);
            check_vec($sformatf("vec%0d", i), tbl[i].emin, tbl[i].esec, tbl[i].erun, tbl[i].edone, tbl[i].ealarm);
        end

        // Two reset cycles while running at 01:30.
        drive(0,1,8'h01,8'h30,0,0,0);
        drive(0,0,8'h00,8'h00,1,0,0);
        drive(0,0,8'h00,8'h00,0,0,1);
        check_model("run_before_rst");
        drive(1,0,8'h00,8'h00,1,0,1);
        check_model("rst_mid_run_1");
        drive(1,0,8'h00,8'h00,0,0,0);
        check_model("rst_mid_run_2");
        drive(0,0,8'h00,8'h00,0,0,0);
        check_vec("after_rst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // Randomized traffic biased toward short counts so expiry is frequent.
        for (int n = 0; n < 4000; n++) begin
            r_r = ($urandom_range(0, 299) == 0);
            r_l = ($urandom_range(0, 14) == 0);
            r_s = ($urandom_range(0, 6) == 0);
            r_p = ($urandom_range(0, 9) == 0);
            r_t = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) begin
                r_lm = 8'($urandom);
                r_ls = 8'($urandom);
            end else begin
                r_lm = 8'h00;
                r_ls = 8'($urandom_range(0, 9));
            end
            drive(r_r, r_l, r_lm, r_ls, r_s, r_p, r_t);
            check_model("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
